// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the arbiter tree and its per-lane ingress buffers.
package arbiter_pkg;

    localparam int DEFAULT_DW = 8;

    // Ceiling log2 evaluated at elaboration for pointer and count widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ingress_fifo_mem.sv
// DEPTH x DW storage for the ingress FIFO: synchronous write, asynchronous read, no reset.
module ingress_fifo_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/arbiter_ingress_fifo.sv
// Per-lane first-word-fall-through buffer ahead of the arbiter tree; all flags come from registered state.
module arbiter_ingress_fifo
    import arbiter_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [DW-1:0]             data_in,
    output logic                      ready_out,
    output logic                      valid_out,
    output logic [DW-1:0]             data_out,
    input  logic                      ready_in,
    output logic [clog2(DEPTH+1)-1:0] count,
    output logic                      almost_full
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = clog2(DEPTH + 1);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(AFULL_TH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
        $error("arbiter_ingress_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_badAfull
        $error("arbiter_ingress_fifo: AFULL_TH must lie in 1..DEPTH");
    end

    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_rdData;

    // Pointers carry an extra wrap bit so full and empty differ only in the MSB.
    assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_push  = valid_in && !w_full && !rst;
    assign w_pop   = !w_empty && ready_in;

    assign ready_out   = !w_full;
    assign valid_out   = !w_empty;
    assign data_out    = w_rdData;
    assign count       = r_count;
    assign almost_full = (r_count >= AFULL_LEVEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    ingress_fifo_mem #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (w_push),
        .waddr(r_wrPtr[AW-1:0]),
        .wdata(data_in),
        .raddr(r_rdPtr[AW-1:0]),
        .rdata(w_rdData)
    );

endmodule
